// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache (16 lines x 32 bytes) between
// the CPU MEM stage and a 256-bit line-wide memory with a request/acknowledge handshake.
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    state_t state, state_next;

    logic [15:0]  valid;
    logic [15:0]  dirty;
    logic [22:0]  tag  [16];
    logic [255:0] data [16];

    logic [3:0]  index;
    logic [2:0]  word;
    logic [22:0] req_tag;
    logic [7:0]  word_lsb;
    logic        hit;
    logic        write_hit;
    logic        refill_done;
    logic        unused_addr;

    assign index       = cpu_addr_i[8:5];
    assign word        = cpu_addr_i[4:2];
    assign req_tag     = cpu_addr_i[31:9];
    assign word_lsb    = {word, 5'b0};
    assign unused_addr = ^cpu_addr_i[1:0];

    assign hit         = valid[index] && (tag[index] == req_tag);
    assign write_hit   = (state == IDLE) && cpu_req_i && cpu_write_i && hit;
    assign refill_done = (state == READMISS) && mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_next;
            if (write_hit) begin
                dirty[index] <= 1'b1;
            end
            if (state == WRITEBACK && mem_ack_i) begin
                dirty[index] <= 1'b0;
            end
            if (refill_done) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end
        end
    end

    // NOTE: tag and data arrays are deliberately left out of reset; valid gates every use
    // of them, and an unreset array can map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (refill_done) begin
            tag[index]  <= req_tag;
            data[index] <= mem_data_i;
        end else if (write_hit) begin
            data[index][word_lsb +: 32] <= cpu_data_i;
        end
    end

    // NOTE: every output and next-state is given a default first so no path infers a latch.
    always_comb begin
        state_next   = state;
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (!cpu_write_i) begin
                            cpu_data_o = data[index][word_lsb +: 32];
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_next  = MISS;
                    end
                end
            end
            MISS: begin
                cpu_stall_o = 1'b1;
                state_next  = (valid[index] && dirty[index]) ? WRITEBACK : READMISS;
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag[index], index, 5'b0};
                mem_data_o   = data[index];
                if (mem_ack_i) begin
                    state_next = MISS;
                end
            end
            READMISS: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, index, 5'b0};
                if (mem_ack_i) begin
                    state_next = READMISSOK;
                end
            end
            READMISSOK: begin
                cpu_stall_o = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: table of CPU accesses against a line-wide
// memory responder, plus hand sequences for reset mid-refill and idle ack noise.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b0;
    logic         cpu_write_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_controller dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model and responder ----------------
    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } txn_t;

    logic [255:0] ext_mem [logic [31:0]];
    txn_t         txn_log [$];
    int           rd_lat = 1;
    int           wb_lat = 1;
    logic         inject_ack = 1'b0;
    int           gap_viol = 0;
    int           stab_viol = 0;

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (ext_mem.exists(a)) return ext_mem[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = a + 32'(w);
        return l;
    endfunction

    initial begin
        int           cnt;
        logic         prev_en;
        logic         prev_ack;
        logic         s_wr;
        logic [31:0]  s_addr;
        logic [255:0] s_data;
        cnt = 0; prev_en = 1'b0; prev_ack = 1'b0;
        s_wr = 1'b0; s_addr = '0; s_data = '0;
        forever begin
            @(negedge clk_i);
            #2;
            if (mem_enable_o) begin
                if (prev_ack) gap_viol++;
                if (prev_en && !prev_ack &&
                    (s_wr !== mem_write_o || s_addr !== mem_addr_o || s_data !== mem_data_o))
                    stab_viol++;
                s_wr = mem_write_o; s_addr = mem_addr_o; s_data = mem_data_o;
                cnt++;
                if (!mem_write_o) mem_data_i = line_of(mem_addr_o);
                if (cnt >= (mem_write_o ? wb_lat : rd_lat)) begin
                    mem_ack_i = 1'b1;
                    txn_log.push_back('{mem_write_o, mem_addr_o, mem_data_o});
                    if (mem_write_o) ext_mem[mem_addr_o] = mem_data_o;
                    cnt = 0;
                end else begin
                    mem_ack_i = 1'b0;
                end
            end else begin
                cnt = 0;
                mem_ack_i = inject_ack;
            end
            prev_en  = mem_enable_o;
            prev_ack = mem_enable_o && mem_ack_i;
        end
    end

    // ---------------- CPU-side tasks ----------------
    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_write_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             output int stalls, output logic [31:0] rdata);
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_data_i = wdata;
        #1;
        stalls = 0;
        while (cpu_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk_i);
            #1;
        end
        rdata = cpu_data_o;
        @(negedge clk_i);
        cpu_req_i = 1'b0; cpu_write_i = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        pre_reset;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rd_lat;
        int          wb_lat;
        int          exp_stall;
        logic [31:0] exp_data;
        int          exp_wb;
        int          exp_rd;
        logic [31:0] wb_addr;
        logic [31:0] rd_addr;
        logic [31:0] wb_w2;
    } vec_t;

    function automatic vec_t mk(input logic pr, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int rl, input int wl,
                                input int es, input logic [31:0] ed, input int ewb,
                                input int erd, input logic [31:0] wba, input logic [31:0] rda,
                                input logic [31:0] w2);
        vec_t v;
        v.pre_reset = pr; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.rd_lat = rl; v.wb_lat = wl; v.exp_stall = es; v.exp_data = ed;
        v.exp_wb = ewb; v.exp_rd = erd; v.wb_addr = wba; v.rd_addr = rda; v.wb_w2 = w2;
        return v;
    endfunction

    task automatic run_vec(input string nm, input vec_t v);
        int          stalls;
        logic [31:0] rdata;
        int          nwb;
        int          nrd;
        rd_lat = v.rd_lat; wb_lat = v.wb_lat;
        txn_log.delete();
        do_access(v.wr, v.addr, v.wdata, stalls, rdata);
        nwb = 0; nrd = 0;
        foreach (txn_log[k]) begin
            if (txn_log[k].wr) nwb++; else nrd++;
        end
        check({nm, "_stall"}, 256'(stalls), 256'(v.exp_stall));
        check({nm, "_data"}, 256'(rdata), 256'(v.exp_data));
        check({nm, "_nwb"}, 256'(nwb), 256'(v.exp_wb));
        check({nm, "_nrd"}, 256'(nrd), 256'(v.exp_rd));
        if (v.exp_wb > 0 && txn_log.size() > 0) begin
            check({nm, "_wb_first"}, 256'(txn_log[0].wr), 256'(1));
            check({nm, "_wb_addr"}, 256'(txn_log[0].addr), 256'(v.wb_addr));
            check({nm, "_wb_w2"}, 256'(txn_log[0].line[95:64]), 256'(v.wb_w2));
        end
        if (v.exp_rd > 0 && txn_log.size() > 0) begin
            check({nm, "_rd_last"}, 256'(txn_log[txn_log.size()-1].wr), 256'(0));
            check({nm, "_rd_addr"}, 256'(txn_log[txn_log.size()-1].addr), 256'(v.rd_addr));
        end
    endtask

    initial begin
        vec_t        vecs [11];
        int          stalls;
        logic [31:0] rdata;

        ext_mem[32'h40] = {32'h47, 32'h46, 32'h45, 32'h44, 32'h43, 32'h42, 32'hDEADBEEF, 32'h0};

        //            rst  wr    addr          wdata         rl wl st exp_data      wb rd wb_addr   rd_addr   wb_w2
        vecs[0]  = mk(1'b1, 1'b0, 32'h0000_0040, 32'h0,        3, 1, 6, 32'h0000_0000, 0, 1, 32'h0,   32'h40,   32'h0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0000_0044, 32'h0,        1, 1, 0, 32'hDEADBEEF,  0, 0, 32'h0,   32'h0,    32'h0);
        vecs[2]  = mk(1'b1, 1'b1, 32'h0000_0048, 32'h12345678, 2, 1, 5, 32'h0000_0000, 0, 1, 32'h0,   32'h40,   32'h0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0000_0048, 32'h0,        1, 1, 0, 32'h12345678,  0, 0, 32'h0,   32'h0,    32'h0);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0000_0248, 32'h0,        2, 3, 9, 32'h0000_0242, 1, 1, 32'h40,  32'h240,  32'h12345678);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0000_0048, 32'h0,        1, 1, 4, 32'h12345678,  0, 1, 32'h0,   32'h40,   32'h0);
        vecs[6]  = mk(1'b0, 1'b1, 32'h0000_01FC, 32'hCAFEF00D, 1, 1, 4, 32'h0000_0000, 0, 1, 32'h0,   32'h1E0,  32'h0);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0000_01FC, 32'h0,        1, 1, 0, 32'hCAFEF00D,  0, 0, 32'h0,   32'h0,    32'h0);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0000_01E4, 32'h0,        1, 1, 0, 32'h0000_01E1, 0, 0, 32'h0,   32'h0,    32'h0);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0000_03E0, 32'h0,        1, 1, 6, 32'h0000_03E0, 1, 1, 32'h1E0, 32'h3E0,  32'h1E2);
        vecs[10] = mk(1'b0, 1'b0, 32'h0000_0080, 32'h0,        1, 1, 4, 32'h0000_0080, 0, 1, 32'h0,   32'h80,   32'h0);

        do_reset();
        #1;
        check("rst_stall", 256'(cpu_stall_o), 256'(0));
        check("rst_enable", 256'(mem_enable_o), 256'(0));
        check("rst_mem_write", 256'(mem_write_o), 256'(0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        check("rst_mem_data", mem_data_o, 256'(0));
        check("rst_cpu_data", 256'(cpu_data_o), 256'(0));

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].pre_reset) do_reset();
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Reset while a refill of 0x280 (index 4, evicting clean 0x80) is outstanding.
        rd_lat = 1000;
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h280;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk_i);
                #1;
                n++;
            end while (!mem_enable_o && n < 20);
            check("rm_reached_readmiss", 256'(mem_enable_o && !mem_write_o), 256'(1));
            check("rm_addr", 256'(mem_addr_o), 256'(32'h280));
        end
        rst_i = 1'b1; cpu_req_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("rm_enable_after_rst", 256'(mem_enable_o), 256'(0));
        check("rm_stall_after_rst", 256'(cpu_stall_o), 256'(0));
        rst_i = 1'b0; inject_ack = 1'b1;
        @(negedge clk_i);
        inject_ack = 1'b0;
        #1;
        check("rm_stray_ack_enable", 256'(mem_enable_o), 256'(0));
        check("rm_stray_ack_stall", 256'(cpu_stall_o), 256'(0));
        run_vec("rm_reload", mk(1'b0, 1'b0, 32'h80, 32'h0, 2, 1, 5, 32'h80, 0, 1, 32'h0, 32'h80, 32'h0));

        // Idle bus with random ack noise must not disturb anything.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            inject_ack = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("idle%0d_stall_enable", c), 256'({cpu_stall_o, mem_enable_o}), 256'(0));
        end
        @(negedge clk_i);
        inject_ack = 1'b0;
        run_vec("idle_after", mk(1'b0, 1'b0, 32'h84, 32'h0, 1, 1, 0, 32'h81, 0, 0, 32'h0, 32'h0, 32'h0));

        check("enable_gap_violations", 256'(gap_viol), 256'(0));
        check("handshake_stability_violations", 256'(stab_viol), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
